// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_e;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int frame_len(input int div, input int data_bits, input int parity,
                                   input int stop_bits);
    return div * (1 + data_bits + ((parity != int'(PAR_NONE)) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Word FIFO in front of the serialiser; extra pointer bit separates full from empty.
// Latency: pushed word visible on dout the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together both honoured.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, data LSB first, optional parity, stop bits); UART_TX_FIFO_EN adds a word FIFO.
// Latency: line falls one edge after accept (two with the FIFO); frame lasts DIV*(1+DATA_BITS+par+STOP_BITS) cycles.
// Backpressure: tx_ready is IDLE without the FIFO, !full with it; writes while not ready are dropped.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 uart_tx
);
  localparam int              DIV       = baud_div(CLK_FREQ, BAUD);
  localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   DIV_M1    = CW'(DIV - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit              HAS_PAR   = (PARITY != int'(PAR_NONE));
  localparam bit              ODD_PAR   = (PARITY == int'(PAR_ODD));

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_param: illegal parameter set");
  end

  tx_state_e            r_state;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_tick;
  logic                 w_load;
  logic [DATA_BITS-1:0] w_word;

  assign w_tick  = (r_baud == DIV_M1);
  assign tx_busy = (r_state != TX_IDLE);
  assign uart_tx = r_tx;

`ifdef UART_TX_FIFO_EN
  logic                 w_full;
  logic                 w_empty;
  logic                 w_last_stop;
  logic [DATA_BITS-1:0] w_fifo_dout;

  // Popping in the final stop cycle chains frames with no idle gap.
  assign w_last_stop = (r_state == TX_STOP) && w_tick && (r_bitcnt == STOP_LAST);
  assign w_load      = !w_empty && ((r_state == TX_IDLE) || w_last_stop);
  assign w_word      = w_fifo_dout;
  assign tx_ready    = !w_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (tx_en),
    .pop    (w_load),
    .din    (tx_data),
    .dout   (w_fifo_dout),
    .full   (w_full),
    .empty  (w_empty)
  );
`else
  assign w_load   = tx_en && (r_state == TX_IDLE);
  assign w_word   = tx_data;
  assign tx_ready = (r_state == TX_IDLE);
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state  <= TX_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
    end else if (w_load) begin
      r_state  <= TX_START;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= w_word;
      r_tx     <= 1'b0;
    end else if (r_state != TX_IDLE) begin
      r_baud <= w_tick ? '0 : r_baud + 1'b1;
      if (w_tick) begin
        unique case (r_state)
          TX_START: begin
            r_state <= TX_DATA;
            r_tx    <= r_shift[0];
            r_par   <= ODD_PAR ? ~^r_shift : ^r_shift;
          end
          TX_DATA: begin
            if (r_bitcnt == DATA_LAST) begin
              r_bitcnt <= '0;
              if (HAS_PAR) begin
                r_state <= TX_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= TX_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
            end
          end
          TX_PAR: begin
            r_state <= TX_STOP;
            r_tx    <= 1'b1;
          end
          TX_STOP: begin
            if (r_bitcnt == STOP_LAST) r_state <= TX_IDLE;
            else                       r_bitcnt <= r_bitcnt + 1'b1;
          end
          default: r_state <= TX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitter flavours (8N1, 8E1, 8O1, 7N2) at DIV=10 driven from one stimulus stream.
// Expected line/busy/ready waveforms come from a per-frame scoreboard checked every cycle.
module tb_uart_tx_param;

  localparam int NDUT = 4;
  localparam int DIV  = 10;
  localparam int DB [NDUT] = '{8, 8, 8, 7};
  localparam int PM [NDUT] = '{0, 2, 1, 0};
  localparam int SB [NDUT] = '{1, 1, 1, 2};
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`endif

  typedef struct {
    int          dut;
    int          push;
    int          start;
    logic [15:0] bits;
  } exp_t;

  logic       sysclk;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       line [NDUT];
  logic       busy [NDUT];
  logic       rdy  [NDUT];

  exp_t        sbq[$];
  int          prev_end [NDUT];
  bit          act [NDUT];
  int          pos [NDUT];
  logic [15:0] fbits [NDUT];
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .sysclk(sysclk), .reset(rst_n), .tx_data(tx_data[7:0]), .tx_en(tx_en),
    .tx_ready(rdy[0]), .tx_busy(busy[0]), .uart_tx(line[0]));
  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
    .sysclk(sysclk), .reset(rst_n), .tx_data(tx_data[7:0]), .tx_en(tx_en),
    .tx_ready(rdy[1]), .tx_busy(busy[1]), .uart_tx(line[1]));
  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .sysclk(sysclk), .reset(rst_n), .tx_data(tx_data[7:0]), .tx_en(tx_en),
    .tx_ready(rdy[2]), .tx_busy(busy[2]), .uart_tx(line[2]));
  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
    .sysclk(sysclk), .reset(rst_n), .tx_data(tx_data[6:0]), .tx_en(tx_en),
    .tx_ready(rdy[3]), .tx_busy(busy[3]), .uart_tx(line[3]));

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, want);
    end
  endtask

  function automatic int flen(input int i);
    return DIV * (1 + DB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i]);
  endfunction

  // Bit sequence LSB first: start, data, parity, then ones for the stop bits.
  function automatic logic [15:0] build(input int i, input logic [7:0] d);
    logic [15:0] b;
    logic        p;
    b    = 16'hFFFF;
    b[0] = 1'b0;
    p    = 1'b0;
    for (int k = 0; k < DB[i]; k++) begin
      b[4'(k + 1)] = d[3'(k)];
      p = p ^ d[3'(k)];
    end
    if (PM[i] == 2) b[4'(DB[i] + 1)] = p;
    if (PM[i] == 1) b[4'(DB[i] + 1)] = ~p;
    return b;
  endfunction

`ifdef UART_TX_FIFO_EN
  function automatic int fifo_cnt(input int i, input int e);
    int n;
    n = 0;
    for (int j = 0; j < sbq.size(); j++)
      if (sbq[j].dut == i && sbq[j].push <= e && sbq[j].start > e) n++;
    return n;
  endfunction
`endif

  function automatic bit any_act();
    bit a;
    a = 1'b0;
    for (int i = 0; i < NDUT; i++) a = a | act[i];
    return a;
  endfunction

  task automatic drive_cycle(input logic en, input logic [7:0] d);
    exp_t e;
    int   s;
    @(posedge sysclk);
    #1;
    tx_en   = en;
    tx_data = d;
    if (en) begin
      for (int i = 0; i < NDUT; i++) begin
`ifdef UART_TX_FIFO_EN
        if (fifo_cnt(i, cyc) < DEPTH) begin
          s = (cyc + 2 > prev_end[i]) ? cyc + 2 : prev_end[i];
`else
        if (cyc >= prev_end[i]) begin
          s = cyc + 1;
`endif
          e.dut   = i;
          e.push  = cyc + 1;
          e.start = s;
          e.bits  = build(i, d);
          sbq.push_back(e);
          prev_end[i] = s + flen(i);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 8'($urandom));
  endtask

  task automatic pulse_reset();
    @(posedge sysclk);
    #2;
    tx_en = 1'b0;
    rst_n = 1'b0;
    sbq.delete();
    for (int i = 0; i < NDUT; i++) prev_end[i] = 0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_now_line%0d", i), 32'(line[i]), 32'd1);
      chk($sformatf("rst_now_rdy%0d", i), 32'(rdy[i]), 32'd1);
    end
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;
  endtask

  // Per-cycle waveform check against the scoreboard.
  initial begin : monitor
    int hit;
    int b;
    bit exp_rdy;
    forever begin
      @(negedge sysclk);
      for (int i = 0; i < NDUT; i++) begin
        if (!rst_n) begin
          act[i] = 1'b0;
          chk($sformatf("rst_line%0d", i), 32'(line[i]), 32'd1);
          chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
          chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'd1);
        end else begin
          hit = -1;
          for (int j = 0; j < sbq.size(); j++)
            if (hit < 0 && sbq[j].dut == i) hit = j;
          if (!act[i] && hit >= 0 && sbq[hit].start == cyc) begin
            act[i]   = 1'b1;
            pos[i]   = 0;
            fbits[i] = sbq[hit].bits;
            sbq.delete(hit);
          end
`ifdef UART_TX_FIFO_EN
          exp_rdy = (fifo_cnt(i, cyc) < DEPTH);
`else
          exp_rdy = !act[i];
`endif
          chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exp_rdy));
          if (act[i]) begin
            b = pos[i] / DIV;
            chk($sformatf("line%0d", i), 32'(line[i]), 32'(fbits[i][4'(b)]));
            chk($sformatf("busy%0d", i), 32'(busy[i]), 32'd1);
            pos[i]++;
            if (pos[i] == flen(i)) act[i] = 1'b0;
          end else begin
            chk($sformatf("idle_line%0d", i), 32'(line[i]), 32'd1);
            chk($sformatf("idle_busy%0d", i), 32'(busy[i]), 32'd0);
          end
        end
      end
    end
  end

  initial begin : stim
    int budget;
    rst_n   = 1'b0;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < NDUT; i++) prev_end[i] = 0;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    idle(3);

    drive_cycle(1'b1, 8'hA5);
    idle(120);
    drive_cycle(1'b1, 8'h55);
    idle(120);

    drive_cycle(1'b1, 8'h3C);
    idle(39);
    drive_cycle(1'b1, 8'hFF);
    idle(130);

    drive_cycle(1'b1, 8'h96);
    idle(34);
    pulse_reset();
    idle(5);
    drive_cycle(1'b1, 8'h5A);
    idle(120);

    // Held write strobe with data changing every cycle.
    repeat (250) drive_cycle(1'b1, 8'($urandom));
    idle(120);

    for (int k = 1; k <= 6; k++) drive_cycle(1'b1, 8'(k));

    budget = 0;
    while ((sbq.size() != 0 || any_act()) && budget < 3000) begin
      drive_cycle(1'b0, 8'($urandom));
      budget++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter and single-clock successor to the fixed 8N1 sender. The baud tick comes from an internal divisor on sysclk, so no separate bit clock is needed. Data width, parity mode and stop-bit count are configurable. The block sits between the CPU's memory-mapped UART registers and the board TX pin, and an optional FIFO allows back-to-back frames.

Parameters:
CLK_FREQ, 100000000, sysclk frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD, truncated; DIV < 2 is an elaboration error
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, entries when UART_TX_FIFO_EN is defined; power of 2, at least 2

Ports:
sysclk  in  1  the only clock; all logic on the rising edge
reset  in  1  asynchronous, active-low
tx_data  in  DATA_BITS  payload, sampled only on accept
tx_en  in  1  write strobe; accept = tx_en && tx_ready at a rising edge
tx_ready  out  1  block can accept a word this cycle
tx_busy  out  1  a frame is on the line (state != IDLE)
uart_tx  out  1  serial line, idle high, registered

Behaviour:
- Reset (async assert, any time, including mid-frame): uart_tx=1, tx_ready=1, tx_busy=0, state=IDLE, baud counter=0, FIFO empty.
- Frame order: start(0), data LSB first, optional parity, STOP_BITS x stop(1). Every bit is held exactly DIV cycles.
- Frame length F = DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
- Parity: even means data^parity has an even number of ones; odd means an odd number. Parity is computed from the latched shift word, not from live tx_data.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE->START on accept (no FIFO) or on FIFO non-empty.
  - START->DATA after DIV cycles.
  - DATA stays for DATA_BITS bit periods, then goes to PAR if PARITY!=0, else STOP.
  - PAR->STOP after DIV cycles.
  - STOP->IDLE after STOP_BITS*DIV cycles.
- Baud counter counts 0..DIV-1. It is cleared on entry to START so the first bit is full width. A bit counter tracks DATA and STOP bits.
- Latency: if accept happens at edge k, uart_tx falls at edge k+1 and tx_busy rises at edge k+1. The last stop bit ends at edge k+1+F, where tx_busy falls.
- Without FIFO:
  - tx_ready = (state==IDLE).
  - tx_en while busy is ignored; no error flag, no data corruption.
  - The minimum gap between frames is therefore 1 idle cycle.
- tx_data may change freely after accept; the word is latched into the shift register.
- tx_en held high continuously (no FIFO) sends one frame, then a new frame on each return to IDLE.

Optional Feature:
UART_TX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the serialiser, and tx_ready = !full.
  - Accept pushes into the FIFO.
  - In the last cycle of the last stop bit, if the FIFO is non-empty, the FSM pops and goes directly to START, giving zero idle cycles between frames.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
  - tx_en when full is dropped.
  - Empty-FIFO latency equals the no-FIFO latency plus 1 cycle (push at k, pop at k+1, start bit at k+2).
- Not defined: behaviour as in the Behaviour section; FIFO_DEPTH is unused.

Decomposition:
- Package uart_pkg holds:
  - the parity enum (PAR_NONE/PAR_ODD/PAR_EVEN);
  - the tx state enum;
  - a constant function for the baud divisor;
  - a frame_len function.
- One sub-module, uart_tx_fifo: synchronous FIFO with the same sysclk/reset, ports push/pop/din/dout/full/empty, pointer width $clog2(FIFO_DEPTH)+1 for full/empty disambiguation.

Test Plan:
1. CLK_FREQ=1000000, BAUD=100000 (DIV=10), 8N1; write 0xA5 at edge 0 -> uart_tx low for cycles 1-10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, high for 91-100; tx_ready returns at edge 101.
2. PARITY=2 with 0xA5 -> parity bit 0 at cycles 91-100; PARITY=1 -> parity 1; both give frame length 110 cycles.
3. STOP_BITS=2, DATA_BITS=7, 0x55 -> 7 data bits 1,0,1,0,1,0,1, then 20 cycles high; tx_busy falls at edge 101.
4. Write 0x3C, then pulse tx_en with 0xFF at cycle 40 (no FIFO) -> ignored, line carries only 0x3C, tx_ready stays 0 until edge 101.
5. Assert reset at cycle 35 mid-frame -> uart_tx=1 and tx_ready=1 immediately, with no glitch low after release; the next write sends a clean frame.
6. UART_TX_FIFO_EN, FIFO_DEPTH=4: write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges ->
   - the first word pops immediately, leaving 4 slots free, so all five are accepted and tx_ready stays 1 throughout;
   - 5 frames go out back-to-back with no idle cycle between stop and start;
   - tx_busy falls 500 cycles after the first start bit.
